reset_seq_multi: RTL and testbench

- Parametrised power-on/restart reset sequencer for board-level peripherals (PHY, codec, sensor) and fabric resets.
- Waits for a filtered PLL/clock lock, holds all channels in reset, then releases N_CH active-low resets in a staggered sequence and flags completion.
- Re-runs the whole sequence on lock loss or a soft-reset request.
- With N_CH=1, i_lock tied high and DONE_CYC>0, it reproduces a single reset output plus a delayed done flag.

---
 rtl/reset_seq_pkg.sv | 16 +
 rtl/reset_lock_filter.sv | 39 +++
 rtl/reset_seq_multi.sv | 148 ++++++++++++++
 tb/tb_reset_seq_multi.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the multi-channel reset sequencer.
// The optional restart counter is enabled by defining RSTSEQ_RESTART_CNT_EN.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        STAGGER   = 3'd2,
        DONE_WAIT = 3'd3,
        DONE      = 3'd4
    } state_e;

    localparam int DEFAULT_CNT_W = 32;
    localparam int RESTART_CNT_W = 8;

endpackage

// File: rtl/reset_lock_filter.sv
// Two-flop synchroniser for the PLL lock plus a consecutive-high filter.
// i_clr (soft reset) clears the synchroniser too, so a restart sees the full lock latency again.
module reset_lock_filter
    import reset_seq_pkg::*;
#(
    parameter int LOCK_FILT = 16,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lock,
    input  logic i_clr,
    output logic lock_ok
);

    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(LOCK_FILT);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= i_lock;
            sync2 <= sync1;
            if (!sync2)
                cnt <= '0;
            else if (cnt != FILT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign lock_ok = (cnt == FILT_MAX);

endmodule

// File: rtl/reset_seq_multi.sv
// Staggered N-channel reset sequencer gated by a filtered PLL lock.
// Define RSTSEQ_RESTART_CNT_EN to add the saturating o_restart_cnt output.
//
// state     | meaning
// WAIT_LOCK | all resets asserted, waiting for filtered lock
// HOLD      | lock seen, counting HOLD_CYC before releasing channel 0
// STAGGER   | releasing channels 1..N_CH-1 every STEP_CYC
// DONE_WAIT | all channels released, counting DONE_CYC
// DONE      | sequence complete, outputs held
module reset_seq_multi
    import reset_seq_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_W     = DEFAULT_CNT_W,
    parameter int LOCK_FILT = 16,
    parameter int HOLD_CYC  = 1000000,
    parameter int STEP_CYC  = 100000,
    parameter int DONE_CYC  = 6000000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_lock,
    input  logic            i_soft_rst,
    output logic [N_CH-1:0] o_rst_n,
    output logic            o_done
`ifdef RSTSEQ_RESTART_CNT_EN
    ,
    output logic [RESTART_CNT_W-1:0] o_restart_cnt
`endif
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'((DONE_CYC > 0) ? DONE_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);

    if (((HOLD_CYC >> CNT_W) != 0) || ((STEP_CYC >> CNT_W) != 0) ||
        ((DONE_CYC >> CNT_W) != 0) || ((LOCK_FILT >> CNT_W) != 0)) begin : g_cnt_w_chk
        $error("reset_seq_multi: a delay parameter does not fit in CNT_W bits");
    end

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [N_CH-1:0]  step_therm;
    logic             lock_ok;
    logic             restart;

    reset_lock_filter #(
        .LOCK_FILT (LOCK_FILT),
        .CNT_W     (CNT_W)
    ) u_lock_filter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_lock  (i_lock),
        .i_clr   (i_soft_rst),
        .lock_ok (lock_ok)
    );

    assign restart = !lock_ok || i_soft_rst;

    // Thermometer with channels 0..idx released; keeps lower bits high by construction.
    always_comb begin
        step_therm = '0;
        for (int k = 0; k < N_CH; k++)
            step_therm[k] = (k <= int'(idx));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            idx     <= '0;
            o_rst_n <= '0;
            o_done  <= 1'b0;
        end else if (restart) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            idx     <= '0;
            o_rst_n <= '0;
            o_done  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        o_rst_n[0] <= 1'b1;
                        cnt        <= '0;
                        if (N_CH > 1) begin
                            state <= STAGGER;
                            idx   <= IDX_W'(1);
                        end else if (DONE_CYC == 0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= DONE_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STAGGER: begin
                    if (cnt == STEP_LAST) begin
                        o_rst_n <= step_therm;
                        cnt     <= '0;
                        if (idx == LAST_IDX) begin
                            if (DONE_CYC == 0) begin
                                state  <= DONE;
                                o_done <= 1'b1;
                            end else begin
                                state <= DONE_WAIT;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE_WAIT: begin
                    if (cnt == DONE_LAST) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: ;
                default: state <= WAIT_LOCK;
            endcase
        end
    end

`ifdef RSTSEQ_RESTART_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_restart_cnt <= '0;
        else if (restart && (state != WAIT_LOCK) && (o_restart_cnt != '1))
            o_restart_cnt <= o_restart_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_reset_seq_multi.sv
// Directed bench for reset_seq_multi: N_CH=3 instance plus an N_CH=1/DONE_CYC=0 instance.
// Covers power-up timeline, lock glitch, lock loss, soft reset and mid-sequence i_rst_n.
module tb_reset_seq_multi;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_lock;
    logic       i_soft_rst;
    logic [2:0] o_rst_n;
    logic       o_done;
    logic [0:0] o1_rst_n;
    logic       o1_done;
`ifdef RSTSEQ_RESTART_CNT_EN
    logic [7:0] o_restart_cnt;
    logic [7:0] o1_restart_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int t = 0;

    always #5 i_clk = ~i_clk;

    reset_seq_multi #(
        .N_CH(3), .CNT_W(8), .LOCK_FILT(4), .HOLD_CYC(10), .STEP_CYC(5), .DONE_CYC(3)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lock(i_lock), .i_soft_rst(i_soft_rst),
        .o_rst_n(o_rst_n), .o_done(o_done)
`ifdef RSTSEQ_RESTART_CNT_EN
        , .o_restart_cnt(o_restart_cnt)
`endif
    );

    reset_seq_multi #(
        .N_CH(1), .CNT_W(8), .LOCK_FILT(4), .HOLD_CYC(10), .STEP_CYC(5), .DONE_CYC(0)
    ) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lock(i_lock), .i_soft_rst(i_soft_rst),
        .o_rst_n(o1_rst_n), .o_done(o1_done)
`ifdef RSTSEQ_RESTART_CNT_EN
        , .o_restart_cnt(o1_restart_cnt)
`endif
    );

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       done;
        logic       rst1;
        logic       done1;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        t++;
    endtask

    task automatic go_to(input int n);
        while (t < n) step();
    endtask

    // Reset with lock low, release, then raise lock so the next edge is E0 (t=0).
    task automatic start_seq();
        i_rst_n    = 1'b0;
        i_lock     = 1'b0;
        i_soft_rst = 1'b0;
        repeat (3) step();
        chk("reset_rst_n", 32'(o_rst_n), 32'h0);
        chk("reset_done", 32'(o_done), 32'h0);
        i_rst_n = 1'b1;
        repeat (2) step();
        i_lock = 1'b1;
        step();
        t = 0;
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            go_to(tbl[i].cyc);
            chk({tag, "_rst_n"}, 32'(o_rst_n), 32'(tbl[i].rst));
            chk({tag, "_done"}, 32'(o_done), 32'(tbl[i].done));
            chk({tag, "_n1_rst_n"}, 32'(o1_rst_n), 32'(tbl[i].rst1));
            chk({tag, "_n1_done"}, 32'(o1_done), 32'(tbl[i].done1));
        end
    endtask

    initial begin
        tbl[0] = '{cyc: 5,  rst: 3'b000, done: 1'b0, rst1: 1'b0, done1: 1'b0};
        tbl[1] = '{cyc: 15, rst: 3'b000, done: 1'b0, rst1: 1'b0, done1: 1'b0};
        tbl[2] = '{cyc: 16, rst: 3'b001, done: 1'b0, rst1: 1'b1, done1: 1'b1};
        tbl[3] = '{cyc: 20, rst: 3'b001, done: 1'b0, rst1: 1'b1, done1: 1'b1};
        tbl[4] = '{cyc: 21, rst: 3'b011, done: 1'b0, rst1: 1'b1, done1: 1'b1};
        tbl[5] = '{cyc: 25, rst: 3'b011, done: 1'b0, rst1: 1'b1, done1: 1'b1};
        tbl[6] = '{cyc: 26, rst: 3'b111, done: 1'b0, rst1: 1'b1, done1: 1'b1};
        tbl[7] = '{cyc: 29, rst: 3'b111, done: 1'b1, rst1: 1'b1, done1: 1'b1};
        tbl[8] = '{cyc: 35, rst: 3'b111, done: 1'b1, rst1: 1'b1, done1: 1'b1};

        // Nominal power-up, then lock loss at F0 and a full rerun.
        start_seq();
        run_table("nominal");
        go_to(40);
        i_lock = 1'b0;
        step();
        t = 0;
        go_to(2);
        chk("lockloss_f2_rst_n", 32'(o_rst_n), 32'h7);
        chk("lockloss_f2_done", 32'(o_done), 32'h1);
        go_to(3);
        chk("lockloss_f3_rst_n", 32'(o_rst_n), 32'h0);
        chk("lockloss_f3_done", 32'(o_done), 32'h0);
        chk("lockloss_f3_n1_rst_n", 32'(o1_rst_n), 32'h0);
`ifdef RSTSEQ_RESTART_CNT_EN
        chk("lockloss_restart_cnt", 32'(o_restart_cnt), 32'd1);
        chk("lockloss_n1_restart_cnt", 32'(o1_restart_cnt), 32'd1);
`endif
        go_to(6);
        i_lock = 1'b1;
        step();
        t = 0;
        run_table("rerun");

        // One-sample lock glitch sampled at E0+3 shifts everything by 4 edges.
        start_seq();
        go_to(2);
        i_lock = 1'b0;
        step();
        i_lock = 1'b1;
        go_to(19);
        chk("glitch_t19_rst_n", 32'(o_rst_n), 32'h0);
        go_to(20);
        chk("glitch_t20_rst_n", 32'(o_rst_n), 32'h1);
        go_to(25);
        chk("glitch_t25_rst_n", 32'(o_rst_n), 32'h3);
        go_to(32);
        chk("glitch_t32_done", 32'(o_done), 32'h0);
        go_to(33);
        chk("glitch_t33_done", 32'(o_done), 32'h1);

        // Soft reset sampled high at E0+23..E0+32.
        start_seq();
        go_to(22);
        chk("soft_pre_rst_n", 32'(o_rst_n), 32'h3);
        i_soft_rst = 1'b1;
        step();
        chk("soft_t23_rst_n", 32'(o_rst_n), 32'h0);
        go_to(32);
        chk("soft_t32_rst_n", 32'(o_rst_n), 32'h0);
        chk("soft_t32_n1_rst_n", 32'(o1_rst_n), 32'h0);
        i_soft_rst = 1'b0;
        go_to(48);
        chk("soft_t48_rst_n", 32'(o_rst_n), 32'h0);
        go_to(49);
        chk("soft_t49_rst_n", 32'(o_rst_n), 32'h1);
        chk("soft_t49_n1_done", 32'(o1_done), 32'h1);
        go_to(61);
        chk("soft_t61_done", 32'(o_done), 32'h0);
        go_to(62);
        chk("soft_t62_done", 32'(o_done), 32'h1);
`ifdef RSTSEQ_RESTART_CNT_EN
        chk("soft_restart_cnt", 32'(o_restart_cnt), 32'd1);
`endif

        // i_rst_n pulsed low for the edge E0+22.
        start_seq();
        go_to(21);
        chk("rstn_pre_rst_n", 32'(o_rst_n), 32'h3);
        i_rst_n = 1'b0;
        step();
        chk("rstn_t22_rst_n", 32'(o_rst_n), 32'h0);
        chk("rstn_t22_done", 32'(o_done), 32'h0);
        chk("rstn_t22_n1_done", 32'(o1_done), 32'h0);
`ifdef RSTSEQ_RESTART_CNT_EN
        chk("rstn_restart_cnt", 32'(o_restart_cnt), 32'd0);
`endif
        i_rst_n = 1'b1;
        go_to(38);
        chk("rstn_t38_rst_n", 32'(o_rst_n), 32'h0);
        go_to(39);
        chk("rstn_t39_rst_n", 32'(o_rst_n), 32'h1);
        go_to(44);
        chk("rstn_t44_rst_n", 32'(o_rst_n), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
